lc3b_imm_gen_pipe: RTL and testbench
====================================

# lc3b_imm_gen_pipe

Registered, multi-lane immediate generator for the LC-3b decode stage. It decodes the opcode of each incoming instruction, produces the correctly sign- or zero-extended and scaled immediate at a configurable word width, and buffers results in a 2-entry skid FIFO with valid/ready handshakes on both sides. It sits between fetch/decode and the register-read stage and lets decode stall without dropping instructions.

## Interface
- WIDTH, 16, output word width in bits; legal range 16 to 64.
- LANES, 1, instructions processed per transfer; all lanes share one handshake.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input transfer offered.
- in_ready  out  1  buffer can accept; equals (count < 2).
- in_instr  in  16*LANES  instruction words; lane i occupies bits [16i+15:16i].
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts head.
- out_imm  out  WIDTH*LANES  immediate per lane, taken from the head entry.
- out_imm_used  out  LANES  lane's opcode/mode actually uses an immediate.

## Operation
- Per-lane decode on opcode = instr[15:12]:
  - ADD 0001 and AND 0101 with instr[5]=1: SEXT(instr[4:0]). With instr[5]=0: imm 0, used 0.
  - BR 0000 and LEA 1110: SEXT(instr[8:0]) << 1.
  - JSR 0100 with instr[11]=1: SEXT(instr[10:0]) << 1. With instr[11]=0 (JSRR): imm 0, used 0.
  - LDB 0010 and STB 0011: SEXT(instr[5:0]), unscaled.
  - LDW 0110, STW 0111, LDI 1010, STI 1011: SEXT(instr[5:0]) << 1.
  - SHF 1101: ZEXT(instr[3:0]).
  - TRAP 1111: ZEXT(instr[7:0]) << 1.
  - JMP 1100, RTI 1000, NOT 1001: imm 0, used 0.
- Sign extension fills to the full WIDTH. The shift is applied before extension, so there is no overflow at any WIDTH of 16 or more.
- FIFO holds 2 entries. Each entry is {imm, used} for all lanes.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. Order is strictly FIFO.
- out_valid = (count != 0).
- Push and pop in the same cycle leave count unchanged. Push is impossible at count=2 because in_ready is 0.
- flush: at the next edge count goes to 0 and both pointers go to 0. Any push or pop in that cycle is discarded. flush has priority over push and pop.
- Reset: count 0, pointers 0, all entry storage 0. Therefore out_valid=0, in_ready=1, out_imm=0, out_imm_used=0.
- With out_valid=0, out_imm and out_imm_used show the entry at the read pointer. Consumers must ignore them.

## Timing
- Latency is 1 cycle. Data accepted at edge k is presented with out_valid=1 after edge k.
- Throughput is 1 transfer per cycle when out_ready is held at 1.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- Decode logic is combinational before the FIFO write. Outputs are driven directly from registers through the read mux.
- Asserting reset mid-transfer clears state immediately, without waiting for clk. The first push after reset deasserts is accepted at the next edge.

## Configuration
- IMM_GEN_TARGET_EN defined:
  - Adds in_pc (input, WIDTH*LANES) and out_target (output, WIDTH*LANES), both stored per entry.
  - For BR, LEA and JSR with instr[11]=1: out_target = in_pc + imm, modulo 2^WIDTH.
  - For every other opcode: out_target = in_pc.
  - Reset value of out_target is 0.
- IMM_GEN_TARGET_EN undefined: the in_pc and out_target ports and their storage do not exist. All other behaviour is identical.

## Test plan
- Reset, then decode sweep with WIDTH=16, LANES=1 and out_ready=1:
  - BR x01FF: imm 0xFFFE.
  - ADD x1025: imm 0x0005, used 1.
  - ADD x1005: imm 0, used 0.
  - TRAP xF025: imm 0x004A.
  - SHF xD01F: imm 0x000F.
  - LDB x2030: imm 0xFFF0.
  - Each result appears 1 cycle after acceptance.
- Backpressure: hold out_ready=0 and push 3 instructions.
  - in_ready drops after the second push and the third is not accepted.
  - Raise out_ready: the first two pop in order and in_ready returns to 1 after the first pop.
- Simultaneous push and pop at count=1 for 10 cycles: count stays 1, order is preserved, out_valid never drops.
- flush with count=2 and in_valid=1 asserted together: next cycle out_valid=0, in_ready=1, and the offered instruction is never output.
- WIDTH=32, LANES=2, lane0 JSR x4FFF and lane1 JSRR x4040:
  - lane0 imm 0xFFFFFFFE, used 1.
  - lane1 imm 0, used 0.
- IMM_GEN_TARGET_EN defined, WIDTH=16, BR x01FF with in_pc=0x0002: out_target=0x0000 (wraps). NOT x903F with in_pc=0x1234: out_target=0x1234.

Source files
------------

// File: rtl/lc3b_imm_gen_pipe_if.sv
// lc3b_imm_gen_pipe_if: handshake and data bundle for lc3b_imm_gen_pipe.
// IMM_GEN_TARGET_EN adds per-lane PC input and target output.
interface lc3b_imm_gen_pipe_if #(parameter int WIDTH = 16, parameter int LANES = 1);
   logic                     in_valid;
   logic                     in_ready;
   logic [16*LANES-1:0]      in_instr;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH*LANES-1:0]   out_imm;
   logic [LANES-1:0]         out_imm_used;
`ifdef IMM_GEN_TARGET_EN
   logic [WIDTH*LANES-1:0]   in_pc;
   logic [WIDTH*LANES-1:0]   out_target;
   modport master (output in_valid, in_instr, out_ready, in_pc,
                   input in_ready, out_valid, out_imm, out_imm_used, out_target);
   modport slave (input in_valid, in_instr, out_ready, in_pc,
                  output in_ready, out_valid, out_imm, out_imm_used, out_target);
`else
   modport master (output in_valid, in_instr, out_ready,
                   input in_ready, out_valid, out_imm, out_imm_used);
   modport slave (input in_valid, in_instr, out_ready,
                  output in_ready, out_valid, out_imm, out_imm_used);
`endif
endinterface

// File: rtl/lc3b_imm_gen_pipe.sv
// lc3b_imm_gen_pipe: multi-lane LC-3b immediate decode feeding a 2-entry skid FIFO.
// IMM_GEN_TARGET_EN adds a stored pc+imm target for BR/LEA/JSR.
module lc3b_imm_gen_pipe #(
   parameter int WIDTH = 16,
   parameter int LANES = 1
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   lc3b_imm_gen_pipe_if.slave bus
);
   localparam int W = WIDTH * LANES;
   logic [W-1:0]     w_imm;
   logic [LANES-1:0] w_used;
   logic [W-1:0]     r_imm [2];
   logic [LANES-1:0] r_used [2];
   logic             r_wp, r_rp;
   logic [1:0]       r_cnt;
   logic             w_push, w_pop;
`ifdef IMM_GEN_TARGET_EN
   logic [W-1:0]     w_tgt;
   logic [W-1:0]     r_tgt [2];
`endif
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [15:0]      w_i;
      logic [WIDTH-1:0] w_v;
      logic             w_u;
      assign w_i = bus.in_instr[16*l +: 16];
      // scaling happens on the narrow field before extension, so no bits are lost
      always_comb begin
         w_v = '0;
         w_u = 1'b1;
         case (w_i[15:12])
            4'h1, 4'h5: begin
               w_v = w_i[5] ? {{(WIDTH-5){w_i[4]}}, w_i[4:0]} : '0;
               w_u = w_i[5];
            end
            4'h0, 4'hE: w_v = {{(WIDTH-10){w_i[8]}}, w_i[8:0], 1'b0};
            4'h4: begin
               w_v = w_i[11] ? {{(WIDTH-12){w_i[10]}}, w_i[10:0], 1'b0} : '0;
               w_u = w_i[11];
            end
            4'h2, 4'h3: w_v = {{(WIDTH-6){w_i[5]}}, w_i[5:0]};
            4'h6, 4'h7, 4'hA, 4'hB: w_v = {{(WIDTH-7){w_i[5]}}, w_i[5:0], 1'b0};
            4'hD: w_v = {{(WIDTH-4){1'b0}}, w_i[3:0]};
            4'hF: w_v = {{(WIDTH-9){1'b0}}, w_i[7:0], 1'b0};
            default: w_u = 1'b0;
         endcase
      end
      assign w_imm[l*WIDTH +: WIDTH] = w_v;
      assign w_used[l] = w_u;
`ifdef IMM_GEN_TARGET_EN
      logic w_t;
      assign w_t = (w_i[15:12] == 4'h0) || (w_i[15:12] == 4'hE) || (w_i[15:12] == 4'h4 && w_i[11]);
      assign w_tgt[l*WIDTH +: WIDTH] = bus.in_pc[l*WIDTH +: WIDTH] + (w_t ? w_v : '0);
`endif
   end
   assign w_push = bus.in_valid && bus.in_ready;
   assign w_pop = bus.out_valid && bus.out_ready;
   assign bus.in_ready = ~r_cnt[1];
   assign bus.out_valid = |r_cnt;
   assign bus.out_imm = r_imm[r_rp];
   assign bus.out_imm_used = r_used[r_rp];
`ifdef IMM_GEN_TARGET_EN
   assign bus.out_target = r_tgt[r_rp];
`endif
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_wp <= 1'b0;
         r_rp <= 1'b0;
         r_imm[0] <= '0;
         r_imm[1] <= '0;
         r_used[0] <= '0;
         r_used[1] <= '0;
`ifdef IMM_GEN_TARGET_EN
         r_tgt[0] <= '0;
         r_tgt[1] <= '0;
`endif
      end else if (flush) begin
         r_cnt <= '0;
         r_wp <= 1'b0;
         r_rp <= 1'b0;
      end else begin
         if (w_push) begin
            r_imm[r_wp] <= w_imm;
            r_used[r_wp] <= w_used;
`ifdef IMM_GEN_TARGET_EN
            r_tgt[r_wp] <= w_tgt;
`endif
            r_wp <= ~r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end
endmodule

// File: tb/tb_lc3b_imm_gen_pipe.sv
// tb_lc3b_imm_gen_pipe: scoreboard bench for a 16x1 and a 32x2 instance.
// Define IMM_GEN_TARGET_EN to also check stored branch targets.
module tb_lc3b_imm_gen_pipe;
   logic clk = 1'b0;
   logic reset, flush;
   logic f2 = 1'b0;
   always #5 clk = ~clk;
   lc3b_imm_gen_pipe_if #(.WIDTH(16), .LANES(1)) b1 ();
   lc3b_imm_gen_pipe_if #(.WIDTH(32), .LANES(2)) b2 ();
   lc3b_imm_gen_pipe #(.WIDTH(16), .LANES(1)) u1 (.clk(clk), .reset(reset), .flush(flush), .bus(b1));
   lc3b_imm_gen_pipe #(.WIDTH(32), .LANES(2)) u2 (.clk(clk), .reset(reset), .flush(f2), .bus(b2));
   typedef struct packed {logic [15:0] imm; logic used; logic [15:0] pc; logic [15:0] tgt;} e1_t;
   e1_t q1[$];
   e1_t x1, e1;
   logic [65:0] q2[$];
   logic [65:0] x2, e2;
   int errs = 0;
   int checks = 0;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   always @(negedge clk) if (!reset) begin
      chk("valid1", 64'(b1.out_valid), 64'(q1.size() != 0));
      chk("ready1", 64'(b1.in_ready), 64'(q1.size() < 2));
      if (flush) q1.delete();
      else begin
         if (b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) chk("spurious1", 64'd1, 64'd0);
            else begin
               e1 = q1.pop_front();
               chk("imm1", 64'(b1.out_imm), 64'(e1.imm));
               chk("used1", 64'(b1.out_imm_used), 64'(e1.used));
`ifdef IMM_GEN_TARGET_EN
               chk("tgt1", 64'(b1.out_target), 64'(e1.tgt));
`endif
            end
         end
         if (b1.in_valid && b1.in_ready) q1.push_back(x1);
      end
   end
   always @(negedge clk) if (!reset) begin
      chk("valid2", 64'(b2.out_valid), 64'(q2.size() != 0));
      if (b2.out_valid && b2.out_ready) begin
         if (q2.size() == 0) chk("spurious2", 64'd1, 64'd0);
         else begin
            e2 = q2.pop_front();
            chk("imm2", b2.out_imm, e2[65:2]);
            chk("used2", 64'(b2.out_imm_used), 64'(e2[1:0]));
         end
      end
      if (b2.in_valid && b2.in_ready) q2.push_back(x2);
   end
   task automatic send1(input logic [15:0] ins, input logic [15:0] imm, input logic u,
                        input logic [15:0] pc, input logic [15:0] tgt);
      b1.in_valid = 1'b1;
      b1.in_instr = ins;
      x1 = '{imm: imm, used: u, pc: pc, tgt: tgt};
`ifdef IMM_GEN_TARGET_EN
      b1.in_pc = x1.pc;
`endif
      @(posedge clk);
      #1;
      b1.in_valid = 1'b0;
   endtask
   task automatic send2(input logic [31:0] ins, input logic [65:0] e);
      b2.in_valid = 1'b1;
      b2.in_instr = ins;
      x2 = e;
      @(posedge clk);
      #1;
      b2.in_valid = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1;
      flush = 1'b0;
      b1.in_valid = 1'b0;
      b1.in_instr = '0;
      b1.out_ready = 1'b1;
      b2.in_valid = 1'b0;
      b2.in_instr = '0;
      b2.out_ready = 1'b1;
`ifdef IMM_GEN_TARGET_EN
      b1.in_pc = '0;
      b2.in_pc = '0;
`endif
      #12;
      chk("rst_valid", 64'(b1.out_valid), 64'd0);
      chk("rst_ready", 64'(b1.in_ready), 64'd1);
      chk("rst_imm", 64'(b1.out_imm), 64'd0);
      chk("rst_used", 64'(b1.out_imm_used), 64'd0);
      chk("rst_imm2", b2.out_imm, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      send2({16'h4040, 16'h4FFF}, {32'h0, 32'hFFFFFFFE, 2'b01});
      send2({16'hF0FF, 16'h2030}, {32'h000001FE, 32'hFFFFFFF0, 2'b11});
      send1(16'h01FF, 16'hFFFE, 1'b1, 16'h0002, 16'h0000);
      send1(16'h1025, 16'h0005, 1'b1, 16'h0000, 16'h0000);
      send1(16'h1005, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      send1(16'hF025, 16'h004A, 1'b1, 16'h0000, 16'h0000);
      send1(16'hD01F, 16'h000F, 1'b1, 16'h0000, 16'h0000);
      send1(16'h2030, 16'hFFF0, 1'b1, 16'h0000, 16'h0000);
      send1(16'hE100, 16'hFE00, 1'b1, 16'h0100, 16'hFF00);
      send1(16'h6021, 16'hFFC2, 1'b1, 16'h0000, 16'h0000);
      send1(16'hC1C0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      send1(16'h301F, 16'h001F, 1'b1, 16'h0000, 16'h0000);
      send1(16'h4801, 16'h0002, 1'b1, 16'h0010, 16'h0012);
      send1(16'h4040, 16'h0000, 1'b0, 16'h0010, 16'h0010);
      send1(16'h507F, 16'hFFFF, 1'b1, 16'h0000, 16'h0000);
      send1(16'hB03F, 16'hFFFE, 1'b1, 16'h0000, 16'h0000);
      send1(16'h8000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
      send1(16'h903F, 16'h0000, 1'b0, 16'h1234, 16'h1234);
      repeat (2) @(posedge clk);
      #1;
      b1.out_ready = 1'b0;
      send1(16'h1025, 16'h0005, 1'b1, 16'h0000, 16'h0000);
      chk("bp_ready1", 64'(b1.in_ready), 64'd1);
      send1(16'hF025, 16'h004A, 1'b1, 16'h0000, 16'h0000);
      chk("bp_ready2", 64'(b1.in_ready), 64'd0);
      send1(16'hD01F, 16'h000F, 1'b1, 16'h0000, 16'h0000);
      chk("bp_blocked", 64'(b1.in_ready), 64'd0);
      b1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_ready_back", 64'(b1.in_ready), 64'd1);
      @(posedge clk);
      #1;
      send1(16'h103F, 16'hFFFF, 1'b1, 16'h0000, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         send1(16'h1020 | 16'(i), 16'(i), 1'b1, 16'h0000, 16'h0000);
         chk("pp_valid", 64'(b1.out_valid), 64'd1);
      end
      @(posedge clk);
      #1;
      b1.out_ready = 1'b0;
      send1(16'h1021, 16'h0001, 1'b1, 16'h0000, 16'h0000);
      send1(16'h1022, 16'h0002, 1'b1, 16'h0000, 16'h0000);
      flush = 1'b1;
      send1(16'h1023, 16'h0003, 1'b1, 16'h0000, 16'h0000);
      flush = 1'b0;
      chk("fl_valid", 64'(b1.out_valid), 64'd0);
      chk("fl_ready", 64'(b1.in_ready), 64'd1);
      b1.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send1(16'h1024, 16'h0004, 1'b1, 16'h0000, 16'h0000);
      b1.out_ready = 1'b0;
      send1(16'h1025, 16'h0005, 1'b1, 16'h0000, 16'h0000);
      #2;
      reset = 1'b1;
      q1.delete();
      q2.delete();
      #1;
      chk("ar_valid", 64'(b1.out_valid), 64'd0);
      chk("ar_ready", 64'(b1.in_ready), 64'd1);
      chk("ar_imm", 64'(b1.out_imm), 64'd0);
      #2;
      reset = 1'b0;
      b1.out_ready = 1'b1;
      send1(16'h2030, 16'hFFF0, 1'b1, 16'h0000, 16'h0000);
      chk("ar_push", 64'(b1.out_valid), 64'd1);
      for (int i = 0; i < 20 && (q1.size() + q2.size()) != 0; i++) @(posedge clk);
      #1;
      chk("drain", 64'(q1.size() + q2.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
